// File: rtl/guess_hist_pkg.sv
// Shared types and constants for the guess-history front end.
package guess_hist_pkg;

  localparam int unsigned DEF_NUM_DIGITS = 4;
  localparam int unsigned DEF_DIGIT_W    = 4;
  localparam int unsigned DEF_GUESS_W    = DEF_NUM_DIGITS * DEF_DIGIT_W;

  // Saturation value of the played-rounds counter.
  localparam logic [7:0] ROUND_MAX = 8'd255;

  // One history entry at the board's default geometry; human guess in the upper half.
  typedef struct packed {
    logic [DEF_GUESS_W-1:0] h;
    logic [DEF_GUESS_W-1:0] c;
  } entry_t;

endpackage

// File: rtl/guess_history_ctrl_if.sv
// Bundle between the game core / pushbuttons and the seven-segment + LED layer.
interface guess_history_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned DEPTH      = 8
);
  localparam int unsigned GW     = NUM_DIGITS * DIGIT_W;
  localparam int unsigned VIEW_W = $clog2(DEPTH);

  logic                    new_game;
  logic                    wr_valid;
  logic [GW-1:0]           h_guess;
  logic [GW-1:0]           c_guess;
  logic                    win;
  logic                    scroll_up_L;
  logic                    scroll_dn_L;

  logic [GW-1:0]           h_disp;
  logic [GW-1:0]           c_disp;
  logic [2*NUM_DIGITS-1:0] blank;
  logic [VIEW_W-1:0]       view_idx;
  logic [7:0]              round_cnt;
  logic                    full;
  logic                    led_win;

  modport master (
    output new_game, wr_valid, h_guess, c_guess, win, scroll_up_L, scroll_dn_L,
    input  h_disp, c_disp, blank, view_idx, round_cnt, full, led_win
  );

  modport slave (
    input  new_game, wr_valid, h_guess, c_guess, win, scroll_up_L, scroll_dn_L,
    output h_disp, c_disp, blank, view_idx, round_cnt, full, led_win
  );

endinterface

// File: rtl/key_pulse.sv
// Raw active-low pushbutton -> single-cycle press pulse (2-flop sync + falling-edge detect).
module key_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic key_l,
  output logic pulse
);

  logic sync1, sync2, sync_prev;

  // Synchronise, remember previous level, and register the falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      pulse     <= 1'b0;
    end else begin
      sync1     <= key_l;
      sync2     <= sync1;
      sync_prev <= sync2;
      pulse     <= sync_prev & ~sync2;
    end
  end

endmodule

// File: rtl/guess_history_ctrl.sv
// Round-history capture, scroll and display driver for the guessing game.
// Optional feature: define GUESS_HIST_BLINK_EN to blink the win LED every BLINK_DIV clocks.
module guess_history_ctrl
  import guess_hist_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int unsigned DIGIT_W    = DEF_DIGIT_W,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic                 clock,
  input  logic                 reset_L,
  guess_history_ctrl_if.slave  bus
);

  localparam int unsigned GW    = NUM_DIGITS * DIGIT_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned BLK_W = 2 * NUM_DIGITS;

  // Entry layout mirrors entry_t, sized by this instance's geometry.
  typedef struct packed {
    logic [GW-1:0] h;
    logic [GW-1:0] c;
  } hist_entry_t;

  hist_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] view_idx;
  logic [CNT_W-1:0] count;
  logic [7:0]       round_cnt;
  logic             full;
  logic             win_lat;
  logic             up_p, dn_p;
  logic [SUM_W-1:0] rd_sum;
  logic [PTR_W-1:0] rd_idx;
  logic [GW-1:0]    h_disp_q, c_disp_q;
  logic [BLK_W-1:0] blank_q;

  key_pulse u_up (.clk(clock), .rst_n(reset_L), .key_l(bus.scroll_up_L), .pulse(up_p));
  key_pulse u_dn (.clk(clock), .rst_n(reset_L), .key_l(bus.scroll_dn_L), .pulse(dn_p));

  // Viewed slot = (wr_ptr - 1 - view_idx) mod DEPTH, without needing a power-of-2 depth.
  always_comb begin
    rd_sum = SUM_W'(wr_ptr) + SUM_W'(DEPTH - 1) - SUM_W'(view_idx);
    rd_idx = (rd_sum >= SUM_W'(DEPTH)) ? PTR_W'(rd_sum - SUM_W'(DEPTH)) : PTR_W'(rd_sum);
  end

  // History storage; not reset, stale entries are hidden by count.
  always_ff @(posedge clock) begin
    if (bus.wr_valid && !bus.new_game) begin
      mem[wr_ptr] <= '{h: bus.h_guess, c: bus.c_guess};
    end
  end

  // Pointer, occupancy, round counter and view offset; new_game > wr_valid > scroll.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      round_cnt <= '0;
      view_idx  <= '0;
    end else if (bus.new_game) begin
      wr_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      round_cnt <= '0;
      view_idx  <= '0;
    end else if (bus.wr_valid) begin
      wr_ptr   <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) begin
        count <= count + CNT_W'(1);
      end
      full     <= (count >= CNT_W'(DEPTH - 1));
      if (round_cnt != ROUND_MAX) begin
        round_cnt <= round_cnt + 8'd1;
      end
      view_idx <= '0;
    end else if ((count != '0) && (up_p ^ dn_p)) begin
      if (up_p && ((CNT_W'(view_idx) + CNT_W'(1)) < count)) begin
        view_idx <= view_idx + PTR_W'(1);
      end else if (dn_p && (view_idx != '0)) begin
        view_idx <= view_idx - PTR_W'(1);
      end
    end
  end

  // Win latch: any cycle with win high sets it; only new_game or reset clear it.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      win_lat <= 1'b0;
    end else if (bus.new_game) begin
      win_lat <= 1'b0;
    end else if (bus.win) begin
      win_lat <= 1'b1;
    end
  end

  // Registered display of the viewed entry; empty history shows dark digits.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      h_disp_q <= '0;
      c_disp_q <= '0;
      blank_q  <= '1;
    end else if (count == '0) begin
      h_disp_q <= '0;
      c_disp_q <= '0;
      blank_q  <= '1;
    end else begin
      h_disp_q <= mem[rd_idx].h;
      c_disp_q <= mem[rd_idx].c;
      blank_q  <= '0;
    end
  end

  assign bus.h_disp    = h_disp_q;
  assign bus.c_disp    = c_disp_q;
  assign bus.blank     = blank_q;
  assign bus.view_idx  = view_idx;
  assign bus.round_cnt = round_cnt;
  assign bus.full      = full;

`ifdef GUESS_HIST_BLINK_EN
  localparam int unsigned DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             blink_on;
  logic             led_q;

  // Blink divider: first high phase starts the cycle after the latch sets.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      div_cnt  <= '0;
      blink_on <= 1'b0;
      led_q    <= 1'b0;
    end else if (!win_lat) begin
      div_cnt  <= '0;
      blink_on <= 1'b0;
      led_q    <= 1'b0;
    end else if (!blink_on) begin
      div_cnt  <= '0;
      blink_on <= 1'b1;
      led_q    <= 1'b1;
    end else if (div_cnt == DIV_W'(BLINK_DIV - 1)) begin
      div_cnt  <= '0;
      led_q    <= ~led_q;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  assign bus.led_win = led_q;
`else
  // Steady LED; a zero divider setting is treated as LED disabled.
  localparam logic BLINK_DIV_VALID = 1'(BLINK_DIV != 0);

  assign bus.led_win = win_lat & BLINK_DIV_VALID;
`endif

endmodule
